lsu_mem_stage: RTL

- Memory-access stage of the RV64I pipeline. It sits directly upstream of the load-data filter.
- It accepts one load or store per transaction from EX and checks alignment and func3 legality.
- It drives a ready/valid data-memory port with byte strobes and shifted store data.
- For loads, it right-aligns the returned 64-bit word so the requested bytes sit at bit 0. It then hands the raw word plus func3 to the filter, which does sign/zero extension.
- Single outstanding transaction; back-pressures EX while busy.

---
 rtl/lsu_mem_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// RV64I memory-access stage: legality/alignment check, single-outstanding dmem
// handshake, store lane steering and load right-alignment for the downstream filter.
module lsu_mem_stage #(
  parameter int XLEN      = 64,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           func3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      store_data,
  input  logic [NREG_BITS-1:0] rd_idx,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [7:0]           dmem_wstrb,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 ld_valid,
  output logic [2:0]           ld_func3,
  output logic [XLEN-1:0]      ld_data,
  output logic [NREG_BITS-1:0] ld_rd,
  output logic                 st_done,
  output logic                 exc_valid,
  output logic [1:0]           exc_cause,
  output logic [XLEN-1:0]      exc_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t                 state_q;
  logic                   req_ready_q;
  logic                   dmem_req_valid_q;
  logic                   dmem_we_q;
  logic [XLEN-1:0]        dmem_addr_q;
  logic [7:0]             dmem_wstrb_q;
  logic [XLEN-1:0]        dmem_wdata_q;
  logic                   ld_valid_q;
  logic [2:0]             ld_func3_q;
  logic [XLEN-1:0]        ld_data_q;
  logic [NREG_BITS-1:0]   ld_rd_q;
  logic                   st_done_q;
  logic                   exc_valid_q;
  logic [1:0]             exc_cause_q;
  logic [XLEN-1:0]        exc_addr_q;
  logic [2:0]             func3_q;
  logic [NREG_BITS-1:0]   rd_q;
  logic [2:0]             off_q;

  logic [2:0]             size_mask_d;
  logic [1:0]             cause_d;
  logic [7:0]             strb_d;
  logic [XLEN-1:0]        wdata_d;

  function automatic logic [7:0] strobe(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   strobe = 8'h01 << off;
      2'b01:   strobe = 8'h03 << off;
      2'b10:   strobe = 8'h0F << off;
      2'b11:   strobe = 8'hFF;
      default: strobe = 8'h00;
    endcase
  endfunction

  // Decode the incoming op: cause 00 means legal; illegal outranks misaligned.
  always_comb begin
    case (func3[1:0])
      2'b00:   size_mask_d = 3'b000;
      2'b01:   size_mask_d = 3'b001;
      2'b10:   size_mask_d = 3'b011;
      2'b11:   size_mask_d = 3'b111;
      default: size_mask_d = 3'b000;
    endcase
    if ((is_load == is_store) || (is_store && func3[2]) || (is_load && (func3 == 3'b111))) begin
      cause_d = 2'b11;
    end else if ((addr[2:0] & size_mask_d) != 3'b000) begin
      cause_d = is_load ? 2'b01 : 2'b10;
    end else begin
      cause_d = 2'b00;
    end
    if (is_load) begin
      strb_d  = 8'h00;
      wdata_d = '0;
    end else begin
      strb_d  = strobe(func3[1:0], addr[2:0]);
      wdata_d = store_data << {addr[2:0], 3'b000};
    end
  end

  // Transaction FSM with all outputs registered; pulse outputs self-clear each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      dmem_req_valid_q <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wstrb_q     <= 8'h00;
      dmem_wdata_q     <= '0;
      ld_valid_q       <= 1'b0;
      ld_func3_q       <= 3'b000;
      ld_data_q        <= '0;
      ld_rd_q          <= '0;
      st_done_q        <= 1'b0;
      exc_valid_q      <= 1'b0;
      exc_cause_q      <= 2'b00;
      exc_addr_q       <= '0;
      func3_q          <= 3'b000;
      rd_q             <= '0;
      off_q            <= 3'b000;
    end else begin
      ld_valid_q  <= 1'b0;
      st_done_q   <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            func3_q <= func3;
            rd_q    <= rd_idx;
            off_q   <= addr[2:0];
            if (cause_d != 2'b00) begin
              exc_valid_q <= 1'b1;
              exc_cause_q <= cause_d;
              exc_addr_q  <= addr;
            end else begin
              state_q          <= REQ;
              req_ready_q      <= 1'b0;
              dmem_req_valid_q <= 1'b1;
              dmem_we_q        <= is_store;
              dmem_addr_q      <= {addr[XLEN-1:3], 3'b000};
              dmem_wstrb_q     <= strb_d;
              dmem_wdata_q     <= wdata_d;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid_q <= 1'b0;
            if (dmem_we_q) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
              st_done_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end else begin
            state_q <= REQ;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            ld_valid_q  <= 1'b1;
            ld_data_q   <= dmem_rdata >> {off_q, 3'b000};
            ld_func3_q  <= func3_q;
            ld_rd_q     <= rd_q;
          end else begin
            state_q <= WAIT;
          end
        end
        default: begin
          state_q          <= IDLE;
          req_ready_q      <= 1'b1;
          dmem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wstrb     = dmem_wstrb_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign ld_valid       = ld_valid_q;
  assign ld_func3       = ld_func3_q;
  assign ld_data        = ld_data_q;
  assign ld_rd          = ld_rd_q;
  assign st_done        = st_done_q;
  assign exc_valid      = exc_valid_q;
  assign exc_cause      = exc_cause_q;
  assign exc_addr       = exc_addr_q;

endmodule
